// File: rtl/gpu_instruction_fifo.sv
// gpu_instruction_fifo
//   Buffers fully decoded draw instructions between the instruction decoder
//   and the rasterizer. Each push captures one complete draw record; the
//   oldest record is presented to the engine first-word-fall-through.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   push_i                   one-cycle push strobe from the decoder
//   opcode_i .. b_i          draw record fields sampled on the push edge
//   ready_i                  engine accepts the head entry this cycle
//   valid_o                  a head entry is present
//   opcode_o .. b_o          head entry fields (0 while valid_o=0)
//   count_o                  occupied entries, 0..DEPTH
//   full_o                   count_o == DEPTH
//   overflow_o               sticky: a push was dropped because the FIFO was full
//
// Handshake: the head entry is transferred on a rising edge where
// valid_o=1 and ready_i=1. ready_i while valid_o=0 has no effect. The head
// fields are held stable while valid_o=1 and ready_i=0.

`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_instruction_fifo #(
  parameter int DEPTH    = 8,
  parameter int PTR_BITS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [3:0]               opcode_i,
  input  logic [`WIDTH_BITS-1:0]   x1_i,
  input  logic [`HEIGHT_BITS-1:0]  y1_i,
  input  logic [`WIDTH_BITS-1:0]   x2_i,
  input  logic [`HEIGHT_BITS-1:0]  y2_i,
  input  logic [`WIDTH_BITS-1:0]   rad_i,
  input  logic [2:0]               oct_i,
  input  logic [`CHANNEL_BITS-1:0] r_i,
  input  logic [`CHANNEL_BITS-1:0] g_i,
  input  logic [`CHANNEL_BITS-1:0] b_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [3:0]               opcode_o,
  output logic [`WIDTH_BITS-1:0]   x1_o,
  output logic [`HEIGHT_BITS-1:0]  y1_o,
  output logic [`WIDTH_BITS-1:0]   x2_o,
  output logic [`HEIGHT_BITS-1:0]  y2_o,
  output logic [`WIDTH_BITS-1:0]   rad_o,
  output logic [2:0]               oct_o,
  output logic [`CHANNEL_BITS-1:0] r_o,
  output logic [`CHANNEL_BITS-1:0] g_o,
  output logic [`CHANNEL_BITS-1:0] b_o,
  output logic [PTR_BITS:0]        count_o,
  output logic                     full_o,
  output logic                     overflow_o
);

  typedef struct packed {
    logic [3:0]               opcode;
    logic [`WIDTH_BITS-1:0]   x1;
    logic [`HEIGHT_BITS-1:0]  y1;
    logic [`WIDTH_BITS-1:0]   x2;
    logic [`HEIGHT_BITS-1:0]  y2;
    logic [`WIDTH_BITS-1:0]   rad;
    logic [2:0]               oct;
    logic [`CHANNEL_BITS-1:0] r;
    logic [`CHANNEL_BITS-1:0] g;
    logic [`CHANNEL_BITS-1:0] b;
  } entry_t;

  entry_t              mem [DEPTH];
  entry_t              wr_entry;
  entry_t              head;
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS:0]   count;
  logic                overflow;
  logic                valid;
  logic                full;
  logic                pop;
  logic                push_ok;

  // valid/full come only from the registered count, so push_i never
  // reaches valid_o combinationally.
  assign valid   = (count != '0);
  assign full    = (count == (PTR_BITS+1)'(DEPTH));
  assign pop     = valid & ready_i;
  // A simultaneous pop frees the slot, so a push into a full FIFO is
  // accepted when the head is leaving on the same edge.
  assign push_ok = push_i & (~full | pop);

  assign wr_entry = '{opcode: opcode_i, x1: x1_i, y1: y1_i, x2: x2_i,
                      y2: y2_i, rad: rad_i, oct: oct_i, r: r_i, g: g_i,
                      b: b_i};

  // Storage needs no reset; its contents are masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_BITS'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PTR_BITS+1)'(1);
        2'b01:   count <= count - (PTR_BITS+1)'(1);
        default: count <= count;
      endcase
      if (push_i && !push_ok) overflow <= 1'b1;
    end
  end

  assign head = valid ? mem[rd_ptr] : '0;

  assign valid_o    = valid;
  assign full_o     = full;
  assign count_o    = count;
  assign overflow_o = overflow;
  assign opcode_o   = head.opcode;
  assign x1_o       = head.x1;
  assign y1_o       = head.y1;
  assign x2_o       = head.x2;
  assign y2_o       = head.y2;
  assign rad_o      = head.rad;
  assign oct_o      = head.oct;
  assign r_o        = head.r;
  assign g_o        = head.g;
  assign b_o        = head.b;

endmodule
